gba_bus_arbiter: RTL and testbench
==================================

// Module: gba_bus_arbiter
// PURPOSE
// - Owns the shared system bus between the ARM7 core wrapper and NUM_DMA DMA channels.
// - Drives dma_active into the CPU wrapper, which pauses the core and tri-states its bus.
// - Grants the bus to DMA only at CPU preemptable points; lowest channel index = highest priority.
// - A higher-priority channel preempts a lower one at a transfer-unit (beat) boundary.
// PARAMETERS
// - NUM_DMA          4   number of DMA requesters
// - HANDBACK_CYCLES  1   turnaround cycles (bus idle, CPU still paused) before the CPU resumes; >=1
// - STALL_CNT_W      32  width of CPU stall counter (ARB_STATS_EN only)
// PORTS
// - clock        in   1            system clock; single clock domain
// - reset_n      in   1            asynchronous, active-low reset
// - preemptable  in   1            CPU is at a point where it may lose the bus
// - dma_req      in   NUM_DMA      per-channel request; level, held until done
// - dma_beat     in   NUM_DMA      granted channel completed one transfer unit this cycle
// - dma_done     in   NUM_DMA      granted channel completed its final unit this cycle
// - dma_grant    out  NUM_DMA      one-hot/zero grant, registered
// - dma_active   out  1            CPU paused, CPU bus drivers released, registered
// - owner_idx    out  $clog2(NUM_DMA)  index of granted channel; 0 when none granted
// - cpu_stall_cycles  out  STALL_CNT_W  cycles with dma_active=1 (ARB_STATS_EN only)
// BEHAVIOUR
// - Reset: state=CPU_OWN; dma_grant=0, dma_active=0, owner_idx=0, cpu_stall_cycles=0.
//   Reset is asynchronous and can occur mid-transfer; no handback is performed.
// - States: CPU_OWN, DMA_OWN, HANDBACK. All outputs are registered.
// - CPU_OWN: if |dma_req && preemptable, go to DMA_OWN next cycle.
//   In that cycle, dma_grant = the one-hot of the lowest set request index, and dma_active=1.
//   The latency from req and preemptable to grant is 1 cycle.
//   A request without preemptable waits in CPU_OWN, with no timeout.
// - DMA_OWN, granted channel g:
//   - dma_done[g]: if other requests are pending, grant the highest pending next cycle
//     (dma_active stays 1). Otherwise go to HANDBACK: grant=0, dma_active=1.
//   - dma_beat[g] without done: if a request of lower index than g is pending, switch the grant
//     to it next cycle. g keeps its request and is re-granted later by priority.
//   - dma_req[g] deasserted without done: treated exactly as done (abort).
//   - done and beat in the same cycle: done wins.
//   - beat/done on a non-granted channel: ignored.
//   - A new request from a lower index arriving mid-beat waits for the next beat/done of g.
// - HANDBACK: count HANDBACK_CYCLES, with dma_grant=0 and dma_active=1.
//   - A request arriving during HANDBACK: go directly to DMA_OWN with the highest pending
//     channel; preemptable is not rechecked, because the CPU is still paused.
//   - Counter expiry with no request: go to CPU_OWN, dma_active=0.
// - Invariants: $onehot0(dma_grant); dma_grant!=0 implies dma_active=1.
//   The grant never changes except on beat, done or abort of the owner.
// - owner_idx follows dma_grant in the same cycle.
// CONFIGURATION
// - ARB_STATS_EN defined: cpu_stall_cycles increments every cycle dma_active=1,
//   saturating at all-ones. It is cleared only by reset.
// - ARB_STATS_EN undefined: port cpu_stall_cycles and its counter are absent;
//   no other behaviour changes.
// STRUCTURE
// - gba_arb_pkg: typedef enum logic [1:0] arb_state_t {CPU_OWN, DMA_OWN, HANDBACK};
//   localparam GBA_NUM_DMA=4; function prio_onehot(req) returning the lowest-set-bit one-hot.
// - Sub-module gba_arb_prio_pick: combinational, parameterised priority picker.
//   Inputs: req vector and a "below index" mask. Outputs: one-hot result plus valid.
// - The FSM, handback counter and stats counter live in gba_bus_arbiter.
// TESTING
// - T1 basic: preemptable=1, dma_req=4'b0100 at cycle 10 -> cycle 11: grant=0100, dma_active=1,
//   owner_idx=2. done[2] at cycle 15 -> cycle 16 grant=0, HANDBACK=1 cycle.
//   Cycle 17: dma_active=0.
// - T2 preempt wait: req=0001 with preemptable=0 for 5 cycles -> grant stays 0, dma_active=0.
//   Raise preemptable -> grant=0001 next cycle.
// - T3 priority preemption: ch3 owns, req[1] rises -> grant unchanged until beat[3].
//   Next cycle grant=0010. done[1] -> grant=1000 next cycle, dma_active never drops.
// - T4 simultaneous/abort: done[2] and beat[2] in the same cycle with req[0] pending
//   -> grant=0001 next cycle. Owner deasserts req without done -> handled as done.
// - T5 handback re-request: req[1] rises during HANDBACK with preemptable=0
//   -> grant=0010 next cycle, dma_active held 1 throughout.
// - T6 reset mid-transfer: assert reset_n=0 while grant=0100 -> grant=0 and dma_active=0
//   immediately (async). Stats build: cpu_stall_cycles=0; counting matches dma_active cycle count.

Source files
------------

// File: rtl/gba_arb_pkg.sv
// gba_arb_pkg: shared arbiter state encoding, channel count and priority helper
package gba_arb_pkg;

    typedef enum logic [1:0] {CPU_OWN, DMA_OWN, HANDBACK} arb_state_t;

    localparam int GBA_NUM_DMA = 4;

    function automatic logic [GBA_NUM_DMA-1:0] prio_onehot(input logic [GBA_NUM_DMA-1:0] req);
        prio_onehot = req & (~req + GBA_NUM_DMA'(1));
    endfunction

endpackage

// File: rtl/gba_arb_prio_pick.sv
// gba_arb_prio_pick: lowest-index-first picker over the requests allowed by a mask
module gba_arb_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] pick,
    output logic         valid
);

    logic [N-1:0] m;

    assign m     = req & mask;
    assign pick  = m & (~m + N'(1));
    assign valid = |m;

endmodule

// File: rtl/gba_bus_arbiter.sv
// gba_bus_arbiter: hands the system bus between the CPU and DMA channels; ARB_STATS_EN adds a CPU stall counter
module gba_bus_arbiter
    import gba_arb_pkg::*;
#(
    parameter int NUM_DMA         = GBA_NUM_DMA,
    parameter int HANDBACK_CYCLES = 1
`ifdef ARB_STATS_EN
    ,
    parameter int STALL_CNT_W     = 32
`endif
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       preemptable,
    input  logic [NUM_DMA-1:0]         dma_req,
    input  logic [NUM_DMA-1:0]         dma_beat,
    input  logic [NUM_DMA-1:0]         dma_done,
    output logic [NUM_DMA-1:0]         dma_grant,
    output logic                       dma_active,
    output logic [$clog2(NUM_DMA)-1:0] owner_idx
`ifdef ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]     cpu_stall_cycles
`endif
);

    localparam int IW = $clog2(NUM_DMA);
    localparam int HW = $clog2(HANDBACK_CYCLES + 1);

    arb_state_t       state, state_nxt;
    logic [NUM_DMA-1:0] grant_nxt, pick_mask, pick;
    logic             pick_valid, active_nxt, own_end, own_beat;
    logic [IW-1:0]    idx_nxt;
    logic [HW-1:0]    hb_cnt, hb_nxt;

    // Owner finishes on done or by dropping its request; done outranks beat
    assign own_end  = |(dma_grant & (dma_done | ~dma_req));
    assign own_beat = |(dma_grant & dma_beat);

    // Mid-transfer only strictly higher-priority channels may take over; after the owner ends any other channel may
    assign pick_mask = (state != DMA_OWN) ? '1 :
                       own_end            ? ~dma_grant : dma_grant - NUM_DMA'(1);

    gba_arb_prio_pick #(.N(NUM_DMA)) u_pick (
        .req   (dma_req),
        .mask  (pick_mask),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Next ownership decision; the CPU stays paused in every state except CPU_OWN
    always_comb begin
        state_nxt = state;
        grant_nxt = dma_grant;
        hb_nxt    = hb_cnt;
        unique case (state)
            CPU_OWN: if (pick_valid && preemptable) begin
                state_nxt = DMA_OWN;
                grant_nxt = pick;
            end
            DMA_OWN: if (own_end) begin
                grant_nxt = pick_valid ? pick : '0;
                if (!pick_valid) begin
                    state_nxt = HANDBACK;
                    hb_nxt    = HW'(HANDBACK_CYCLES - 1);
                end
            end else if (own_beat && pick_valid) begin
                grant_nxt = pick;
            end
            HANDBACK: if (pick_valid) begin
                state_nxt = DMA_OWN;
                grant_nxt = pick;
            end else if (hb_cnt == '0) begin
                state_nxt = CPU_OWN;
            end else begin
                hb_nxt = hb_cnt - HW'(1);
            end
            default: begin
                state_nxt = CPU_OWN;
                grant_nxt = '0;
            end
        endcase
        active_nxt = state_nxt != CPU_OWN;
    end

    // Owner index is derived from the next grant so it lands in the same cycle as the grant
    always_comb begin
        idx_nxt = '0;
        for (int i = 0; i < NUM_DMA; i++) if (grant_nxt[i]) idx_nxt = IW'(i);
    end

    // State and registered outputs; reset drops the bus back to the CPU immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CPU_OWN;
            dma_grant  <= '0;
            dma_active <= 1'b0;
            owner_idx  <= '0;
            hb_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            dma_grant  <= grant_nxt;
            dma_active <= active_nxt;
            owner_idx  <= idx_nxt;
            hb_cnt     <= hb_nxt;
        end
    end

`ifdef ARB_STATS_EN
    // Saturating count of cycles the CPU spends paused
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cpu_stall_cycles <= '0;
        else if (dma_active && !(&cpu_stall_cycles)) cpu_stall_cycles <= cpu_stall_cycles + STALL_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_gba_bus_arbiter.sv
// tb_gba_bus_arbiter: directed scenarios checked against an ownership model every cycle
module tb_gba_bus_arbiter;

    localparam int HB = 1;

    typedef struct {
        int owner;
        bit paused;
        int hb;
    } mstate_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       preemptable = 1'b0;
    logic [3:0] dma_req = '0, dma_beat = '0, dma_done = '0;
    logic [3:0] dma_grant;
    logic       dma_active;
    logic [1:0] owner_idx;
`ifdef ARB_STATS_EN
    logic [31:0] cpu_stall_cycles;
    int          stall_m;
`endif

    int errors = 0;
    int checks = 0;
    mstate_t m;

    gba_bus_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .preemptable (preemptable),
        .dma_req     (dma_req),
        .dma_beat    (dma_beat),
        .dma_done    (dma_done),
        .dma_grant   (dma_grant),
        .dma_active  (dma_active),
        .owner_idx   (owner_idx)
`ifdef ARB_STATS_EN
        ,
        .cpu_stall_cycles (cpu_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic [3:0] req, input logic [3:0] beat,
                                     input logic [3:0] done, input logic pre);
        mstate_t n = s;
        logic [3:0] others;
        logic [3:0] higher;
        if (s.owner >= 0) begin
            if (done[s.owner] || !req[s.owner]) begin
                others = req;
                others[s.owner] = 1'b0;
                n.owner = lowest(others);
                if (n.owner < 0) n.hb = HB;
            end else if (beat[s.owner]) begin
                higher = '0;
                for (int i = 0; i < s.owner; i++) higher[i] = req[i];
                if (lowest(higher) >= 0) n.owner = lowest(higher);
            end
        end else if (s.paused) begin
            n.owner = lowest(req);
            if (n.owner < 0) n.hb = s.hb - 1;
            n.paused = n.owner >= 0 || n.hb > 0;
        end else if (pre && lowest(req) >= 0) begin
            n.owner = lowest(req);
            n.paused = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_grant(input mstate_t s);
        return s.owner < 0 ? 4'b0000 : 4'b0001 << s.owner;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m <= '{owner: -1, paused: 1'b0, hb: 0};
`ifdef ARB_STATS_EN
            stall_m <= 0;
`endif
        end else begin
            m <= step(m, dma_req, dma_beat, dma_done, preemptable);
`ifdef ARB_STATS_EN
            if (m.paused) stall_m <= stall_m + 1;
`endif
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("model_grant", 32'(dma_grant), 32'(exp_grant(m)));
            check("model_active", 32'(dma_active), 32'(m.paused));
            check("model_owner_idx", 32'(owner_idx), 32'(m.owner < 0 ? 0 : m.owner));
`ifdef ARB_STATS_EN
            check("model_stall", cpu_stall_cycles, 32'(stall_m));
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic a, input logic [1:0] idx);
        check({name, "_grant"}, 32'(dma_grant), 32'(g));
        check({name, "_active"}, 32'(dma_active), 32'(a));
        check({name, "_idx"}, 32'(owner_idx), 32'(idx));
    endtask

    initial begin
        tick(2);
        expect_out("reset", 4'b0000, 1'b0, 2'd0);
`ifdef ARB_STATS_EN
        check("reset_stall", cpu_stall_cycles, 32'd0);
`endif
        reset_n = 1'b1;
        tick(3);

        // T1 basic grant, done, one handback cycle
        preemptable = 1'b1; dma_req = 4'b0100;
        tick();
        expect_out("t1_grant", 4'b0100, 1'b1, 2'd2);
        dma_beat = 4'b0100;
        tick();
        dma_beat = 4'b0000;
        tick(2);
        expect_out("t1_hold", 4'b0100, 1'b1, 2'd2);
        dma_done = 4'b0100;
        tick();
        dma_done = 4'b0000; dma_req = 4'b0000;
        expect_out("t1_handback", 4'b0000, 1'b1, 2'd0);
        tick();
        expect_out("t1_cpu", 4'b0000, 1'b0, 2'd0);

        // T2 request waits for a preemptable point
        preemptable = 1'b0; dma_req = 4'b0001;
        tick(5);
        expect_out("t2_wait", 4'b0000, 1'b0, 2'd0);
        preemptable = 1'b1;
        tick();
        expect_out("t2_grant", 4'b0001, 1'b1, 2'd0);
        dma_done = 4'b0001;
        tick();
        dma_done = 4'b0000; dma_req = 4'b0000;
        tick(2);

        // T3 higher priority preempts only at a beat boundary
        dma_req = 4'b1000;
        tick();
        expect_out("t3_own3", 4'b1000, 1'b1, 2'd3);
        dma_req = 4'b1010;
        tick(2);
        expect_out("t3_wait_beat", 4'b1000, 1'b1, 2'd3);
        dma_beat = 4'b1000;
        tick();
        dma_beat = 4'b0000;
        expect_out("t3_preempt", 4'b0010, 1'b1, 2'd1);
        tick();
        dma_done = 4'b0010; dma_req = 4'b1000;
        tick();
        dma_done = 4'b0000;
        expect_out("t3_regrant", 4'b1000, 1'b1, 2'd3);
        dma_done = 4'b1000;
        tick();
        dma_done = 4'b0000; dma_req = 4'b0000;
        tick(2);

        // T4 done+beat together, foreign beat ignored, abort by request drop
        dma_req = 4'b0100;
        tick();
        dma_req = 4'b0101;
        tick();
        expect_out("t4_no_beat", 4'b0100, 1'b1, 2'd2);
        dma_done = 4'b0100; dma_beat = 4'b0100; dma_req = 4'b0001;
        tick();
        dma_done = 4'b0000; dma_beat = 4'b0000;
        expect_out("t4_done_wins", 4'b0001, 1'b1, 2'd0);
        dma_req = 4'b0101; dma_beat = 4'b0100; dma_done = 4'b0100;
        tick();
        dma_beat = 4'b0000; dma_done = 4'b0000;
        expect_out("t4_foreign", 4'b0001, 1'b1, 2'd0);
        dma_req = 4'b0100;
        tick();
        expect_out("t4_abort", 4'b0100, 1'b1, 2'd2);
        dma_req = 4'b0000;
        tick();
        expect_out("t4_abort_hb", 4'b0000, 1'b1, 2'd0);
        tick(2);

        // T5 request during handback regains the bus without preemptable
        dma_req = 4'b0100;
        tick();
        dma_done = 4'b0100; dma_req = 4'b0000;
        tick();
        dma_done = 4'b0000; preemptable = 1'b0; dma_req = 4'b0010;
        expect_out("t5_hb", 4'b0000, 1'b1, 2'd0);
        tick();
        expect_out("t5_regrant", 4'b0010, 1'b1, 2'd1);
        dma_done = 4'b0010; dma_req = 4'b0000;
        tick();
        dma_done = 4'b0000; preemptable = 1'b1;
        tick(2);

        // T6 asynchronous reset mid-transfer
        dma_req = 4'b0100;
        tick();
        expect_out("t6_own", 4'b0100, 1'b1, 2'd2);
        #2 reset_n = 1'b0;
        #1;
        expect_out("t6_async", 4'b0000, 1'b0, 2'd0);
`ifdef ARB_STATS_EN
        check("t6_stall", cpu_stall_cycles, 32'd0);
`endif
        dma_req = 4'b0000;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        expect_out("t6_after", 4'b0000, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
